command_word_fetch: RTL

COMMAND_WORD_FETCH -- requirements
Module: command_word_fetch

---
 rtl/command_word_fetch_pkg.sv | 25 ++
 rtl/command_word_fetch_if.sv | 27 ++
 rtl/command_word_fetch_delay_counter.sv | 27 ++
 rtl/command_word_fetch.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/command_word_fetch_pkg.sv
// Shared command package: FSM state encoding and the no-op address default
// used by the command word fetcher and the downstream command decoders.
package command_word_fetch_pkg;

  localparam int CMD_WORD_W = 16;

  // Address field value that marks a word as a no-op (dropped, never dispatched).
  localparam logic [11:0] CMD_NOP_ADDRESS = 12'hFFF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_PRESENT = 3'd4,
    ST_GAP     = 3'd5
  } cwf_state_e;

  // Word layout: [15:4] address, [3:0] payload.
  function automatic logic cmd_is_nop(input logic [CMD_WORD_W-1:0] word,
                                      input logic [11:0]            nop_addr);
    return word[15:4] == nop_addr;
  endfunction

endpackage

// File: rtl/command_word_fetch_if.sv
// Command word fetch bus: FIFO pop side plus the dispatched-word strobe.
//   FifoEmpty         FIFO -> fetcher   command FIFO empty flag
//   FifoDout          FIFO -> fetcher   read data, valid READ_LATENCY cycles after pop
//   FifoRdEn          fetcher -> FIFO   single-cycle pop strobe
//   CommandFifoReadEn fetcher -> decoders  single-cycle word-valid strobe
//   COMMAND_WORD      fetcher -> decoders  dispatched word
// master = the fetcher, slave = FIFO/decoder environment.
interface command_word_fetch_if;
  import command_word_fetch_pkg::*;

  logic                  FifoEmpty;
  logic [CMD_WORD_W-1:0] FifoDout;
  logic                  FifoRdEn;
  logic                  CommandFifoReadEn;
  logic [CMD_WORD_W-1:0] COMMAND_WORD;

  modport master (
    input  FifoEmpty, FifoDout,
    output FifoRdEn, CommandFifoReadEn, COMMAND_WORD
  );

  modport slave (
    output FifoEmpty, FifoDout,
    input  FifoRdEn, CommandFifoReadEn, COMMAND_WORD
  );

endinterface

// File: rtl/command_word_fetch_delay_counter.sv
// cmd_delay_counter: loadable 4-bit down-counter with a done flag.
//   Clk      clock
//   reset_n  asynchronous active-low reset (count -> 0)
//   i_load   load i_value this cycle (takes priority over counting)
//   i_value  load value
//   o_done   count is zero
// The count stops at zero, so a load of N gives N+1 cycles before done
// is seen by a state that starts checking the cycle after the load.
module cmd_delay_counter (
  input  logic       Clk,
  input  logic       reset_n,
  input  logic       i_load,
  input  logic [3:0] i_value,
  output logic       o_done
);

  logic [3:0] r_count;

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n)               r_count <= 4'd0;
    else if (i_load)            r_count <= i_value;
    else if (r_count != 4'd0)   r_count <= r_count - 4'd1;
  end

  assign o_done = (r_count == 4'd0);

endmodule

// File: rtl/command_word_fetch.sv
// command_word_fetch: pops 16-bit command words from a FIFO, drops no-op
// words, presents the rest to the decoders with a one-cycle strobe, then
// enforces an idle gap before the next fetch.
//   Clk, reset_n     clock; async-assert / sync-release active-low reset
//   Enable           level, permits starting a new fetch
//   i_CountLoad      one-cycle preload of CommandCount with i_CountLoadVal
//   bus (master)     FIFO pop + dispatched word/strobe (see command_word_fetch_if)
//   Busy             high in every state except IDLE
//   CommandCount     words dispatched since reset (wraps)
//   NopCount         no-op words dropped since reset (saturates)
// All outputs come straight from registers.
module command_word_fetch
  import command_word_fetch_pkg::*;
#(
  parameter int          READ_LATENCY = 1,   // 1..3
  parameter int          GAP_CYCLES   = 2,   // 0..15
  parameter logic [11:0] NOP_ADDRESS  = CMD_NOP_ADDRESS
) (
  input  logic                  Clk,
  input  logic                  reset_n,
  input  logic                  Enable,
  input  logic                  i_CountLoad,
  input  logic [15:0]           i_CountLoadVal,
  command_word_fetch_if.master  bus,
  output logic                  Busy,
  output logic [15:0]           CommandCount,
  output logic [7:0]            NopCount
);

  // WAIT lasts READ_LATENCY-1 cycles; with latency 1 it is skipped entirely.
  localparam logic [3:0] WAIT_LOAD = (READ_LATENCY > 1) ? 4'(READ_LATENCY - 2) : 4'd0;
  localparam logic [3:0] GAP_LOAD  = (GAP_CYCLES > 0)   ? 4'(GAP_CYCLES - 1)   : 4'd0;
  // With no gap, the single cycle after a word is the IDLE re-arm cycle, which
  // keeps the word period at READ_LATENCY+3+GAP_CYCLES for every setting.
  localparam bit         HAS_GAP   = (GAP_CYCLES != 0);

  // Reset: asserts asynchronously, releases on the second Clk edge.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) r_rst_sync <= 2'b00;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[1];

  cwf_state_e  r_state;
  logic        r_fifo_rd_en;
  logic        r_cmd_rd_en;
  logic        r_busy;
  logic [15:0] r_word;
  logic [15:0] r_cmd_count;
  logic [7:0]  r_nop_count;

  logic w_is_nop;
  logic w_wait_load, w_wait_done;
  logic w_gap_load,  w_gap_done;

  assign w_is_nop    = cmd_is_nop(bus.FifoDout, NOP_ADDRESS);
  assign w_wait_load = (r_state == ST_ISSUE);
  assign w_gap_load  = (r_state == ST_PRESENT) || ((r_state == ST_CAPTURE) && w_is_nop);

  cmd_delay_counter u_wait_cnt (
    .Clk     (Clk),
    .reset_n (w_rst_n),
    .i_load  (w_wait_load),
    .i_value (WAIT_LOAD),
    .o_done  (w_wait_done)
  );

  cmd_delay_counter u_gap_cnt (
    .Clk     (Clk),
    .reset_n (w_rst_n),
    .i_load  (w_gap_load),
    .i_value (GAP_LOAD),
    .o_done  (w_gap_done)
  );

  always_ff @(posedge Clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state      <= ST_IDLE;
      r_fifo_rd_en <= 1'b0;
      r_cmd_rd_en  <= 1'b0;
      r_busy       <= 1'b0;
      r_word       <= 16'h0000;
      r_cmd_count  <= 16'h0000;
      r_nop_count  <= 8'h00;
    end else begin
      r_fifo_rd_en <= 1'b0;
      r_cmd_rd_en  <= 1'b0;
      case (r_state)
        // FifoEmpty and Enable are only looked at here, so a pop never
        // hits an empty FIFO and a dropped Enable lets the current word finish.
        ST_IDLE: begin
          if (Enable && !bus.FifoEmpty) begin
            r_state      <= ST_ISSUE;
            r_fifo_rd_en <= 1'b1;
            r_busy       <= 1'b1;
          end
        end
        ST_ISSUE:
          r_state <= (READ_LATENCY > 1) ? ST_WAIT : ST_CAPTURE;
        ST_WAIT:
          if (w_wait_done) r_state <= ST_CAPTURE;
        // FifoDout is valid this cycle; no-ops never touch the word register.
        ST_CAPTURE: begin
          if (w_is_nop) begin
            if (r_nop_count != 8'hFF) r_nop_count <= r_nop_count + 8'd1;
            r_state <= HAS_GAP ? ST_GAP : ST_IDLE;
            r_busy  <= HAS_GAP;
          end else begin
            r_word      <= bus.FifoDout;
            r_cmd_rd_en <= 1'b1;
            r_cmd_count <= r_cmd_count + 16'd1;
            r_state     <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          r_state <= HAS_GAP ? ST_GAP : ST_IDLE;
          r_busy  <= HAS_GAP;
        end
        ST_GAP: begin
          if (w_gap_done) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
      if (i_CountLoad) r_cmd_count <= i_CountLoadVal;
    end
  end

  assign bus.FifoRdEn          = r_fifo_rd_en;
  assign bus.CommandFifoReadEn = r_cmd_rd_en;
  assign bus.COMMAND_WORD      = r_word;
  assign Busy                  = r_busy;
  assign CommandCount          = r_cmd_count;
  assign NopCount              = r_nop_count;

endmodule
